// File: rtl/adder_pkg.sv
// Shared definitions for the shared-adder arbiter: op codes, FSM states, flag bundle.
package adder_pkg;

   localparam int DATA_W = 8;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_RSV = 2'b10;
   localparam logic [1:0] OP_NEG = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef struct packed {
      logic carry;
      logic eq;
      logic gt;
      logic lt;
      logic err;
   } rsp_flags_t;

endpackage

// File: rtl/adder.sv
// 8-bit add/sub/negate unit with carry and unsigned compare flags; purely combinational.
module adder
   import adder_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [1:0]        sel,
   output logic [DATA_W-1:0] adder_out,
   output rsp_flags_t        flags
);

   logic [DATA_W:0] sum_wide;

   assign sum_wide = {1'b0, a} + {1'b0, b};

   // Select the result by op code; compare flags always reflect A and B, carry only for add.
   always_comb begin
      adder_out   = '0;
      flags       = '0;
      flags.eq    = (a == b);
      flags.gt    = (a > b);
      flags.lt    = (a < b);
      case (sel)
         OP_ADD: begin
            adder_out   = sum_wide[DATA_W-1:0];
            flags.carry = sum_wide[DATA_W];
         end
         OP_SUB: begin
            adder_out = a - b;
         end
         OP_NEG: begin
            adder_out = ~b + 8'd1;
         end
         default: begin
            flags.err = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: first valid requester at or above rr_ptr, wrapping past NUM_REQ-1.
module rr_arbiter #(
   parameter  int NUM_REQ = 2,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx,
   output logic               grant_valid
);

   logic [ID_W:0]   cand;
   logic [ID_W-1:0] cand_idx;

   // Walk the requesters starting at rr_ptr and take the first one that is valid.
   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      cand        = '0;
      cand_idx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (cand >= (ID_W+1)'(NUM_REQ)) begin
            cand = cand - (ID_W+1)'(NUM_REQ);
         end
         cand_idx = cand[ID_W-1:0];
         if (!grant_valid && req_valid[cand_idx]) begin
            grant_valid     = 1'b1;
            grant_idx       = cand_idx;
            grant[cand_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one adder among NUM_REQ valid/ready requesters; results return tagged with the ID.
// Each operation walks IDLE -> EXEC -> RESP, so accept at T gives rsp_valid at T+2.
module adder_arbiter
   import adder_pkg::*;
#(
   parameter  int NUM_REQ = 2,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [NUM_REQ*8-1:0]  req_a,
   input  logic [NUM_REQ*8-1:0]  req_b,
   input  logic [NUM_REQ*2-1:0]  req_sel,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [ID_W-1:0]       rsp_id,
   output logic [DATA_W-1:0]     rsp_data,
   output logic                  rsp_carry,
   output logic                  rsp_eq,
   output logic                  rsp_gt,
   output logic                  rsp_lt,
   output logic                  rsp_err
);

   state_e            state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [DATA_W-1:0] op_a_q, op_a_d;
   logic [DATA_W-1:0] op_b_q, op_b_d;
   logic [1:0]        op_sel_q, op_sel_d;
   logic [ID_W-1:0]   op_id_q, op_id_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   rsp_flags_t        rsp_flags_q, rsp_flags_d;

   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    grant_idx;
   logic               grant_valid;
   logic [DATA_W-1:0]  adder_out;
   rsp_flags_t         adder_flags;

   logic accept;
   logic load_rsp;
   logic rsp_fire;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
      .req_valid   (req_valid),
      .rr_ptr      (rr_ptr_q),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   adder u_adder (
      .a         (op_a_q),
      .b         (op_b_q),
      .sel       (op_sel_q),
      .adder_out (adder_out),
      .flags     (adder_flags)
   );

   // State register; reset drops any in-flight operation back to IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: leave IDLE on any grant, EXEC always lasts one cycle, RESP waits for rsp_ready.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM outputs: ready only toward the granted requester in IDLE, held low while in reset.
   always_comb begin
      req_ready = '0;
      accept    = 1'b0;
      load_rsp  = 1'b0;
      rsp_fire  = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = rst_n ? grant : '0;
            accept    = grant_valid;
         end
         EXEC: begin
            load_rsp = 1'b1;
         end
         RESP: begin
            rsp_fire = rsp_ready;
         end
         default: begin
            req_ready = '0;
         end
      endcase
   end

   // Datapath next values: latch the winner's operands, capture the adder result, advance rr_ptr.
   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      op_sel_d    = op_sel_q;
      op_id_d     = op_id_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      rsp_flags_d = rsp_flags_q;
      if (accept) begin
         op_id_d = grant_idx;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
               op_a_d   = req_a[8*i +: 8];
               op_b_d   = req_b[8*i +: 8];
               op_sel_d = req_sel[2*i +: 2];
            end
         end
      end
      if (load_rsp) begin
         rsp_valid_d = 1'b1;
         rsp_id_d    = op_id_q;
         rsp_data_d  = adder_out;
         rsp_flags_d = adder_flags;
      end
      if (rsp_fire) begin
         rsp_valid_d = 1'b0;
         rr_ptr_d    = (rsp_id_q == ID_W'(NUM_REQ-1)) ? '0 : rsp_id_q + 1'b1;
      end
   end

   // Datapath registers, all cleared by reset so every output reads zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q    <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         op_sel_q    <= '0;
         op_id_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
         rsp_flags_q <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         op_sel_q    <= op_sel_d;
         op_id_q     <= op_id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         rsp_flags_q <= rsp_flags_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_carry = rsp_flags_q.carry;
   assign rsp_eq    = rsp_flags_q.eq;
   assign rsp_gt    = rsp_flags_q.gt;
   assign rsp_lt    = rsp_flags_q.lt;
   assign rsp_err   = rsp_flags_q.err;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: a 2-requester instance for most scenarios and a
// 3-requester instance for round-robin pointer wrap.
module tb_adder_arbiter;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic [3:0]  req_sel;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [0:0]  rsp_id;
   logic [7:0]  rsp_data;
   logic        rsp_carry, rsp_eq, rsp_gt, rsp_lt, rsp_err;
   logic [4:0]  flags2;

   logic [2:0]  req_valid_3;
   logic [2:0]  req_ready_3;
   logic [23:0] req_a_3;
   logic [23:0] req_b_3;
   logic [5:0]  req_sel_3;
   logic        rsp_valid_3;
   logic        rsp_ready_3;
   logic [1:0]  rsp_id_3;
   logic [7:0]  rsp_data_3;
   logic        rsp_carry_3, rsp_eq_3, rsp_gt_3, rsp_lt_3, rsp_err_3;

   assign flags2 = {rsp_carry, rsp_eq, rsp_gt, rsp_lt, rsp_err};

   int checks   = 0;
   int failures = 0;

   logic [7:0] cap_data;
   logic [4:0] cap_flags;
   logic [0:0] cap_id;
   logic       cap_ok;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [1:0] sel;
      logic [7:0] data;
      logic [4:0] flags;
   } vec_t;

   // flags are {carry, eq, gt, lt, err}
   vec_t vecs [6] = '{
      '{a: 8'h00, b: 8'h01, sel: 2'b01, data: 8'hFF, flags: 5'b00010},
      '{a: 8'h12, b: 8'h80, sel: 2'b11, data: 8'h80, flags: 5'b00010},
      '{a: 8'h00, b: 8'h00, sel: 2'b11, data: 8'h00, flags: 5'b01000},
      '{a: 8'h55, b: 8'h44, sel: 2'b10, data: 8'h00, flags: 5'b00101},
      '{a: 8'hFF, b: 8'h01, sel: 2'b00, data: 8'h00, flags: 5'b10100},
      '{a: 8'h80, b: 8'h7F, sel: 2'b01, data: 8'h01, flags: 5'b00100}
   };

   adder_arbiter #(.NUM_REQ(2)) dut2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_sel   (req_sel),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_carry (rsp_carry),
      .rsp_eq    (rsp_eq),
      .rsp_gt    (rsp_gt),
      .rsp_lt    (rsp_lt),
      .rsp_err   (rsp_err)
   );

   adder_arbiter #(.NUM_REQ(3)) dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid_3),
      .req_ready (req_ready_3),
      .req_a     (req_a_3),
      .req_b     (req_b_3),
      .req_sel   (req_sel_3),
      .rsp_valid (rsp_valid_3),
      .rsp_ready (rsp_ready_3),
      .rsp_id    (rsp_id_3),
      .rsp_data  (rsp_data_3),
      .rsp_carry (rsp_carry_3),
      .rsp_eq    (rsp_eq_3),
      .rsp_gt    (rsp_gt_3),
      .rsp_lt    (rsp_lt_3),
      .rsp_err   (rsp_err_3)
   );

   // Issue one request on the 2-requester instance and capture its response (bounded waits).
   task automatic run_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] sel);
      logic got;
      got    = 1'b0;
      cap_ok = 1'b0;
      rsp_ready = 1'b1;
      req_a[8*idx +: 8]   = a;
      req_b[8*idx +: 8]   = b;
      req_sel[2*idx +: 2] = sel;
      req_valid[idx]      = 1'b1;
      for (int c = 0; c < 10 && !got; c++) begin
         #1;
         if (req_ready[idx] === 1'b1) got = 1'b1;
         @(negedge clk);
      end
      req_valid[idx] = 1'b0;
      if (got) begin
         for (int c = 0; c < 10 && !cap_ok; c++) begin
            if (rsp_valid === 1'b1) begin
               cap_data  = rsp_data;
               cap_flags = flags2;
               cap_id    = rsp_id;
               cap_ok    = 1'b1;
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset();
      int seen;
      rst_n     = 1'b0;
      rsp_ready = 1'b0;
      req_valid = 2'b11;
      req_a     = 16'h0000;
      req_b     = 16'h0000;
      req_sel   = 4'h0;
      repeat (2) @(negedge clk);
      checks++;
      if (req_ready !== 2'b00) begin
         failures++;
         $display("[TB] FAIL reset_req_ready: got %b expected 00", req_ready);
      end
      checks++;
      if ({rsp_valid, rsp_id, rsp_data, flags2} !== 15'd0) begin
         failures++;
         $display("[TB] FAIL reset_rsp: got %h expected 0", {rsp_valid, rsp_id, rsp_data, flags2});
      end
      req_valid = 2'b00;
      rst_n     = 1'b1;
      @(negedge clk);
      req_a[7:0]  = 8'h11;
      req_b[7:0]  = 8'h22;
      req_sel[1:0] = 2'b00;
      req_valid   = 2'b01;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         failures++;
         $display("[TB] FAIL reset_first_ready: got %b expected 01", req_ready);
      end
      @(negedge clk);
      req_valid = 2'b00;
      rst_n     = 1'b0;
      #1;
      checks++;
      if ({req_ready, rsp_valid, rsp_id, rsp_data, flags2} !== 17'd0) begin
         failures++;
         $display("[TB] FAIL reset_exec_outputs: got %h expected 0",
                  {req_ready, rsp_valid, rsp_id, rsp_data, flags2});
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      seen  = 0;
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0) seen++;
      end
      checks++;
      if (seen !== 0) begin
         failures++;
         $display("[TB] FAIL reset_no_response: got %0d responses expected 0", seen);
      end
      rsp_ready   = 1'b0;
      req_a[7:0]  = 8'hF0;
      req_b[7:0]  = 8'h20;
      req_valid   = 2'b01;
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_resp_reached: got %b expected 1", rsp_valid);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_data, flags2} !== 15'd0) begin
         failures++;
         $display("[TB] FAIL reset_resp_outputs: got %h expected 0",
                  {rsp_valid, rsp_id, rsp_data, flags2});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_add();
      rsp_ready    = 1'b0;
      req_a[7:0]   = 8'hF0;
      req_b[7:0]   = 8'h20;
      req_sel[1:0] = 2'b00;
      req_valid    = 2'b01;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         failures++;
         $display("[TB] FAIL add_ready: got %b expected 01", req_ready);
      end
      @(negedge clk);
      req_valid = 2'b00;
      checks++;
      if (rsp_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL add_latency_t1: got %b expected 0", rsp_valid);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1) begin
         failures++;
         $display("[TB] FAIL add_latency_t2: got %b expected 1", rsp_valid);
      end
      checks++;
      if (rsp_data !== 8'h10) begin
         failures++;
         $display("[TB] FAIL add_data: got %h expected 10", rsp_data);
      end
      checks++;
      if (flags2 !== 5'b10100) begin
         failures++;
         $display("[TB] FAIL add_flags: got %b expected 10100", flags2);
      end
      checks++;
      if (rsp_id !== 1'b0) begin
         failures++;
         $display("[TB] FAIL add_id: got %0d expected 0", rsp_id);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL add_handshake: got %b expected 0", rsp_valid);
      end
      rsp_ready = 1'b0;
   endtask

   task automatic test_round_robin();
      int n;
      int r_cyc [8];
      logic [0:0] r_id [8];
      logic [7:0] r_dat [8];
      int exp_cyc [4]  = '{2, 5, 8, 11};
      logic [0:0] exp_id [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [7:0] exp_dat [4] = '{8'h03, 8'h0D, 8'h03, 8'h0D};
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b1;
      req_a   = {8'h10, 8'h01};
      req_b   = {8'h03, 8'h02};
      req_sel = {2'b01, 2'b00};
      req_valid = 2'b11;
      n = 0;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1 && n < 8) begin
            r_cyc[n] = cyc;
            r_id[n]  = rsp_id;
            r_dat[n] = rsp_data;
            n++;
         end
      end
      req_valid = 2'b00;
      checks++;
      if (n !== 4) begin
         failures++;
         $display("[TB] FAIL rr_count: got %0d responses expected 4", n);
      end
      for (int k = 0; k < 4; k++) begin
         if (k < n) begin
            checks++;
            if (r_id[k] !== exp_id[k] || r_cyc[k] !== exp_cyc[k] || r_dat[k] !== exp_dat[k]) begin
               failures++;
               $display("[TB] FAIL rr_rsp%0d: got id=%0d cyc=%0d data=%h expected id=%0d cyc=%0d data=%h",
                        k, r_id[k], r_cyc[k], r_dat[k], exp_id[k], exp_cyc[k], exp_dat[k]);
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int bad;
      rsp_ready     = 1'b0;
      req_a[15:8]   = 8'h33;
      req_b[15:8]   = 8'h33;
      req_sel[3:2]  = 2'b01;
      req_valid     = 2'b10;
      #1;
      checks++;
      if (req_ready !== 2'b10) begin
         failures++;
         $display("[TB] FAIL bp_ready1: got %b expected 10", req_ready);
      end
      @(negedge clk);
      req_a[7:0]   = 8'h05;
      req_b[7:0]   = 8'h07;
      req_sel[1:0] = 2'b00;
      req_valid    = 2'b01;
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_id, rsp_data, flags2, req_ready} !== {1'b1, 1'b1, 8'h00, 5'b01000, 2'b00}) begin
         failures++;
         $display("[TB] FAIL bp_first_resp: got v=%b id=%0d data=%h flags=%b ready=%b expected v=1 id=1 data=00 flags=01000 ready=00",
                  rsp_valid, rsp_id, rsp_data, flags2, req_ready);
      end
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 8'h00 ||
             flags2 !== 5'b01000 || req_ready !== 2'b00) bad++;
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("[TB] FAIL bp_stall_stable: got %0d unstable cycles expected 0", bad);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({rsp_valid, req_ready} !== 3'b0_01) begin
         failures++;
         $display("[TB] FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=01",
                  rsp_valid, req_ready);
      end
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_id, rsp_data, flags2} !== {1'b1, 1'b0, 8'h0C, 5'b00010}) begin
         failures++;
         $display("[TB] FAIL bp_waiting_req: got v=%b id=%0d data=%h flags=%b expected v=1 id=0 data=0c flags=00010",
                  rsp_valid, rsp_id, rsp_data, flags2);
      end
      @(negedge clk);
   endtask

   task automatic test_ops();
      logic [0:0] exp_id;
      for (int k = 0; k < 6; k++) begin
         exp_id = 1'(k % 2);
         run_op(k % 2, vecs[k].a, vecs[k].b, vecs[k].sel);
         checks++;
         if (cap_ok !== 1'b1) begin
            failures++;
            $display("[TB] FAIL op%0d_timeout: got no response expected one", k);
         end else begin
            checks++;
            if (cap_data !== vecs[k].data || cap_flags !== vecs[k].flags || cap_id !== exp_id) begin
               failures++;
               $display("[TB] FAIL op%0d: got data=%h flags=%b id=%0d expected data=%h flags=%b id=%0d",
                        k, cap_data, cap_flags, cap_id, vecs[k].data, vecs[k].flags, exp_id);
            end
         end
      end
   endtask

   task automatic test_wrap();
      rsp_ready_3 = 1'b1;
      req_a_3[23:16]  = 8'h07;
      req_b_3[23:16]  = 8'h03;
      req_sel_3[5:4]  = 2'b01;
      req_valid_3     = 3'b100;
      #1;
      checks++;
      if (req_ready_3 !== 3'b100) begin
         failures++;
         $display("[TB] FAIL wrap_grant2: got %b expected 100", req_ready_3);
      end
      @(negedge clk);
      req_valid_3 = 3'b000;
      @(negedge clk);
      checks++;
      if ({rsp_valid_3, rsp_id_3, rsp_data_3} !== {1'b1, 2'd2, 8'h04}) begin
         failures++;
         $display("[TB] FAIL wrap_rsp2: got v=%b id=%0d data=%h expected v=1 id=2 data=04",
                  rsp_valid_3, rsp_id_3, rsp_data_3);
      end
      @(negedge clk);
      req_a_3 = {8'h09, 8'h20, 8'h01};
      req_b_3 = {8'h01, 8'h05, 8'h01};
      req_sel_3 = {2'b00, 2'b01, 2'b00};
      req_valid_3 = 3'b101;
      #1;
      checks++;
      if (req_ready_3 !== 3'b001) begin
         failures++;
         $display("[TB] FAIL wrap_ptr_to_0: got %b expected 001", req_ready_3);
      end
      @(negedge clk);
      req_valid_3 = 3'b110;
      @(negedge clk);
      checks++;
      if ({rsp_valid_3, rsp_id_3, rsp_data_3} !== {1'b1, 2'd0, 8'h02}) begin
         failures++;
         $display("[TB] FAIL wrap_rsp0: got v=%b id=%0d data=%h expected v=1 id=0 data=02",
                  rsp_valid_3, rsp_id_3, rsp_data_3);
      end
      @(negedge clk);
      checks++;
      if (req_ready_3 !== 3'b010) begin
         failures++;
         $display("[TB] FAIL wrap_ptr_to_1: got %b expected 010", req_ready_3);
      end
      @(negedge clk);
      req_valid_3 = 3'b100;
      @(negedge clk);
      checks++;
      if ({rsp_valid_3, rsp_id_3, rsp_data_3} !== {1'b1, 2'd1, 8'h1B}) begin
         failures++;
         $display("[TB] FAIL wrap_rsp1: got v=%b id=%0d data=%h expected v=1 id=1 data=1b",
                  rsp_valid_3, rsp_id_3, rsp_data_3);
      end
      @(negedge clk);
      checks++;
      if (req_ready_3 !== 3'b100) begin
         failures++;
         $display("[TB] FAIL wrap_ptr_to_2: got %b expected 100", req_ready_3);
      end
      @(negedge clk);
      req_valid_3 = 3'b000;
      @(negedge clk);
      checks++;
      if ({rsp_valid_3, rsp_id_3, rsp_data_3} !== {1'b1, 2'd2, 8'h0A}) begin
         failures++;
         $display("[TB] FAIL wrap_rsp2_late: got v=%b id=%0d data=%h expected v=1 id=2 data=0a",
                  rsp_valid_3, rsp_id_3, rsp_data_3);
      end
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      req_valid_3 = 3'b000;
      req_a_3     = 24'h0;
      req_b_3     = 24'h0;
      req_sel_3   = 6'h0;
      rsp_ready_3 = 1'b0;
      $display("[TB] starting adder_arbiter bench");
      test_reset();
      test_single_add();
      test_round_robin();
      test_backpressure();
      test_ops();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
